// File: rtl/shreg_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shreg_sequencer_pkg
//  Description : Shared op codes and FSM state encodings for the shift
//                register sequencer and its companion shift register.
//  Revision    : 1.0
// ============================================================================
package shreg_sequencer_pkg;

    // Command / shift-register select encoding
    typedef enum logic [1:0] {
        OP_SHR  = 2'b00,
        OP_SHL  = 2'b01,
        OP_SHT  = 2'b10,
        OP_LOAD = 2'b11
    } op_e;

    // Sequencer states; ST_SETTLE is only reachable in readback builds
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_SETTLE = 2'b10,
        ST_FIN    = 2'b11
    } state_e;

    // LOAD always occupies exactly one enable cycle; shifts use the count
    function automatic logic op_has_cycles(input logic [1:0] op, input logic count_nz);
        return (op == OP_LOAD) || count_nz;
    endfunction

endpackage : shreg_sequencer_pkg
`default_nettype wire

// File: rtl/shreg_seq_counter.sv
`default_nettype none
// ============================================================================
//  Module      : shreg_seq_counter
//  Description : Loadable down-counter with a zero flag; saturates at zero.
//  Revision    : 1.0
// ============================================================================
module shreg_seq_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    // Load takes priority over decrement; never wrap below zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule : shreg_seq_counter
`default_nettype wire

// File: rtl/shreg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : shreg_sequencer
//  Description : Expands one handshaked command into the per-cycle
//                enable/select/serial/parallel stream for the 8-bit
//                multi-mode shift register, then pulses done.
//                Optional feature macro: SHREG_SEQ_READBACK_EN adds a
//                settle cycle and captures the register into rd_data.
//  Revision    : 1.0
// ============================================================================
module shreg_sequencer
    import shreg_sequencer_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int SER_W  = 3,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [CNT_W-1:0]  cmd_count,
    input  logic [SER_W-1:0]  cmd_serial,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              abort,
    output logic              sr_enable,
    output logic [1:0]        sr_select,
    output logic [SER_W-1:0]  sr_serial_in,
    output logic [DATA_W-1:0] sr_parallel_in,
    input  logic [DATA_W-1:0] sr_parallel_out,
    output logic              busy,
    output logic              done,
    output logic              aborted
`ifdef SHREG_SEQ_READBACK_EN
    ,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
`endif
);

`ifdef SHREG_SEQ_READBACK_EN
    localparam state_e c_post_run  = ST_SETTLE;
    localparam logic   c_readback  = 1'b1;
`else
    localparam state_e c_post_run  = ST_FIN;
    localparam logic   c_readback  = 1'b0;
    // Register output is only consumed by the readback capture
    logic w_unused_pout;
    assign w_unused_pout = ^sr_parallel_out;
`endif

    state_e           r_state;
    logic             w_accept;
    logic             w_cnt_zero;
    logic [CNT_W-1:0] w_load_val;

    // Only IDLE accepts, and cmd_ready is high exactly in IDLE
    assign w_accept   = (r_state == ST_IDLE) && cmd_valid;
    // Counter holds cycles remaining after the current one
    assign w_load_val = (cmd_op == OP_LOAD) ? '0 : (cmd_count - CNT_W'(1));

    shreg_seq_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_accept),
        .i_load_val (w_load_val),
        .i_dec      (r_state == ST_RUN),
        .o_zero     (w_cnt_zero)
    );

    // Sequencer FSM; every output is registered and changes with the state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            cmd_ready      <= 1'b1;
            sr_enable      <= 1'b0;
            sr_select      <= 2'b00;
            sr_serial_in   <= '0;
            sr_parallel_in <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            aborted        <= 1'b0;
`ifdef SHREG_SEQ_READBACK_EN
            rd_data        <= '0;
            rd_valid       <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        // Output registers double as the command latch
                        sr_select      <= cmd_op;
                        sr_serial_in   <= cmd_serial;
                        sr_parallel_in <= cmd_data;
                        cmd_ready      <= 1'b0;
                        busy           <= 1'b1;
                        if (op_has_cycles(cmd_op, cmd_count != '0)) begin
                            r_state   <= ST_RUN;
                            sr_enable <= 1'b1;
                        end else begin
                            r_state   <= c_post_run;
                            done      <= ~c_readback;
                        end
                    end
                end
                ST_RUN: begin
                    // The final shift wins over a coincident abort
                    if (w_cnt_zero || abort) begin
                        r_state   <= c_post_run;
                        sr_enable <= 1'b0;
                        done      <= ~c_readback;
                        aborted   <= ~w_cnt_zero;
                    end
                end
`ifdef SHREG_SEQ_READBACK_EN
                ST_SETTLE: begin
                    // Register has absorbed the last shift by now
                    r_state  <= ST_FIN;
                    done     <= 1'b1;
                    rd_data  <= sr_parallel_out;
                    rd_valid <= 1'b1;
                end
`endif
                ST_FIN: begin
                    r_state   <= ST_IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    aborted   <= 1'b0;
`ifdef SHREG_SEQ_READBACK_EN
                    rd_valid  <= 1'b0;
`endif
                end
                default: begin
                    r_state   <= ST_IDLE;
                    cmd_ready <= 1'b1;
                    sr_enable <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    aborted   <= 1'b0;
                end
            endcase
        end
    end

endmodule : shreg_sequencer
`default_nettype wire

// File: tb/tb_shreg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shreg_sequencer
//  Description : Directed self-checking bench for shreg_sequencer with a
//                simple behavioural 8-bit shift register on the sr_* bus.
//  Revision    : 1.0
// ============================================================================
module tb_shreg_sequencer;

`ifdef SHREG_SEQ_READBACK_EN
    localparam int c_rb = 1;
`else
    localparam int c_rb = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_count;
    logic [2:0] cmd_serial;
    logic [7:0] cmd_data;
    logic       abort;
    logic       sr_enable;
    logic [1:0] sr_select;
    logic [2:0] sr_serial_in;
    logic [7:0] sr_parallel_in;
    logic [7:0] sr_parallel_out;
    logic       busy;
    logic       done;
    logic       aborted;
`ifdef SHREG_SEQ_READBACK_EN
    logic [7:0] rd_data;
    logic       rd_valid;
`endif

    int n_total = 0;
    int n_bad   = 0;

    // Statistics gathered by run_cmd
    int   n_en, n_done, n_busy, done_k, field_bad, rdy_after;
    logic ab_at_done;
    logic [7:0] q_at_done;
    int   rv_at_done, n_rv;

    always #5 clk = ~clk;

    shreg_sequencer #(
        .DATA_W (8),
        .SER_W  (3),
        .CNT_W  (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_count       (cmd_count),
        .cmd_serial      (cmd_serial),
        .cmd_data        (cmd_data),
        .abort           (abort),
        .sr_enable       (sr_enable),
        .sr_select       (sr_select),
        .sr_serial_in    (sr_serial_in),
        .sr_parallel_in  (sr_parallel_in),
        .sr_parallel_out (sr_parallel_out),
        .busy            (busy),
        .done            (done),
        .aborted         (aborted)
`ifdef SHREG_SEQ_READBACK_EN
        ,
        .rd_data         (rd_data),
        .rd_valid        (rd_valid)
`endif
    );

    // Behavioural shift register: SHR/SHT insert serial[0] at MSB, SHL at LSB
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_parallel_out <= 8'h00;
        end else if (sr_enable) begin
            case (sr_select)
                2'b00:   sr_parallel_out <= {sr_serial_in[0], sr_parallel_out[7:1]};
                2'b01:   sr_parallel_out <= {sr_parallel_out[6:0], sr_serial_in[0]};
                2'b10:   sr_parallel_out <= {sr_serial_in[0], sr_parallel_out[7:1]};
                default: sr_parallel_out <= sr_parallel_in;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one command, then watch ncyc cycles; abort_k=0 asserts abort with
    // the command, abort_k=k asserts it during the k-th cycle after acceptance
    task automatic run_cmd(input logic [1:0] op, input logic [3:0] cnt,
                           input logic [2:0] ser, input logic [7:0] data,
                           input int abort_k, input int ncyc);
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_count  = cnt;
        cmd_serial = ser;
        cmd_data   = data;
        abort      = (abort_k == 0);
        @(negedge clk);
        // Scramble command inputs to show they are not re-sampled
        cmd_valid  = 1'b0;
        cmd_op     = ~op;
        cmd_count  = ~cnt;
        cmd_serial = ~ser;
        cmd_data   = ~data;
        abort      = 1'b0;
        n_en = 0; n_done = 0; n_busy = 0; done_k = 0; field_bad = 0;
        rdy_after = -1; ab_at_done = 1'b0; q_at_done = 8'h00;
        rv_at_done = 0; n_rv = 0;
        for (int k = 1; k <= ncyc; k++) begin
            if (sr_enable) begin
                n_en++;
                if (sr_select != op || sr_serial_in != ser || sr_parallel_in != data)
                    field_bad++;
            end
            if (busy) n_busy++;
            if (done_k != 0 && k == done_k + 1) rdy_after = int'(cmd_ready);
            if (done) begin
                n_done++;
                if (done_k == 0) begin
                    done_k     = k;
                    ab_at_done = aborted;
                    q_at_done  = sr_parallel_out;
`ifdef SHREG_SEQ_READBACK_EN
                    rv_at_done = int'(rd_valid);
                    q_at_done  = rd_data;
`endif
                end
            end
`ifdef SHREG_SEQ_READBACK_EN
            if (rd_valid) n_rv++;
`endif
            abort = (k == abort_k);
            @(negedge clk);
        end
        abort = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_count = 4'd0;
        cmd_serial = 3'd0; cmd_data = 8'h00; abort = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_ready",  cmd_ready, 1);
        chk("rst_enable", sr_enable, 0);
        chk("rst_select", sr_select, 0);
        chk("rst_pin",    {sr_serial_in, sr_parallel_in}, 0);
        chk("rst_busy",   {busy, done, aborted}, 0);

        // LOAD A5 (count field ignored)
        run_cmd(2'b11, 4'd7, 3'd0, 8'hA5, -1, 6);
        chk("load_en",     n_en, 1);
        chk("load_fields", field_bad, 0);
        chk("load_donek",  done_k, 2 + c_rb);
        chk("load_q",      q_at_done, 8'hA5);
        chk("load_ndone",  n_done, 1);
        chk("load_ab",     ab_at_done, 0);

        // Preload AA then SHR 3 serial 1: AA->D5->EA->F5
        run_cmd(2'b11, 4'd0, 3'd0, 8'hAA, -1, 5);
        chk("preload_q",   q_at_done, 8'hAA);
        run_cmd(2'b00, 4'd3, 3'b001, 8'h00, -1, 8);
        chk("shr_en",      n_en, 3);
        chk("shr_fields",  field_bad, 0);
        chk("shr_donek",   done_k, 4 + c_rb);
        chk("shr_busy",    n_busy, 4 + c_rb);
        chk("shr_q",       q_at_done, 8'hF5);
        chk("shr_rdy",     rdy_after, 1);

        // SHL count 0: no enables, immediate done
        run_cmd(2'b01, 4'd0, 3'b111, 8'h00, -1, 5);
        chk("shl0_en",     n_en, 0);
        chk("shl0_donek",  done_k, 1 + c_rb);
        chk("shl0_rdy",    rdy_after, 1);
        chk("shl0_q",      q_at_done, 8'hF5);

        // SHT 10 with abort during the 3rd run cycle
        run_cmd(2'b10, 4'd10, 3'b000, 8'h00, 3, 10);
        chk("abt_en",      n_en, 3);
        chk("abt_donek",   done_k, 4 + c_rb);
        chk("abt_flag",    ab_at_done, 1);
        chk("abt_ndone",   n_done, 1);
        chk("abt_q",       q_at_done, 8'h1E);

        // Abort coinciding with the last run cycle: full shift, not aborted
        run_cmd(2'b01, 4'd2, 3'b001, 8'h00, 2, 6);
        chk("abtl_en",     n_en, 2);
        chk("abtl_flag",   ab_at_done, 0);
        chk("abtl_q",      q_at_done, 8'h7B);

        // Abort together with cmd_valid in IDLE: command still runs
        run_cmd(2'b11, 4'd0, 3'd0, 8'h5A, 0, 5);
        chk("abti_en",     n_en, 1);
        chk("abti_flag",   ab_at_done, 0);
        chk("abti_q",      q_at_done, 8'h5A);

        // Reset during a long run
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_count = 4'd8; cmd_serial = 3'd1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("rrun_en",     sr_enable, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rrun_state",  {sr_enable, busy, cmd_ready, done}, 4'b0010);
        n_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("rrun_nodone", n_done, 0);

`ifdef SHREG_SEQ_READBACK_EN
        // LOAD 3C then SHL 2 serial 0 -> F0 captured with done
        run_cmd(2'b11, 4'd0, 3'd0, 8'h3C, -1, 5);
        run_cmd(2'b01, 4'd2, 3'd0, 8'h00, -1, 7);
        chk("rb_data",     q_at_done, 8'hF0);
        chk("rb_valid",    rv_at_done, 1);
        chk("rb_nvalid",   n_rv, 1);
        chk("rb_hold",     rd_data, 8'hF0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_shreg_sequencer
`default_nettype wire
